patmos: RTL and testbench

Minimal Patmos-style 32-bit processor top: a multi-cycle, non-pipelined core that fetches from an internal 256-word instruction ROM, executes a 16-opcode integer ISA on 16 registers, and reaches the outside world only through memory-mapped I/O. The I/O map has an 8-bit LED register and a pass-through UART register port. This is the top-level block a board or simulation bench instantiates.

---
 rtl/patmos.sv | 175 +++++++++++++++++
 tb/tb_patmos.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/patmos.sv
// Minimal Patmos-style multi-cycle 32-bit core with internal instruction ROM.
// Reaches the outside world only through an LED register and a UART port.
module patmos #(
  parameter string ROM_FILE = "boot.hex"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] io_dummy,
  output logic [7:0]  io_led,
  output logic [3:0]  io_uart_address,
  output logic [31:0] io_uart_wr_data,
  output logic        io_uart_rd,
  output logic        io_uart_wr,
  input  logic [31:0] io_uart_rd_data
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADDI, OP_ADD, OP_SUB,
    OP_AND, OP_OR,   OP_XOR, OP_SHL,
    OP_SHR, OP_LUI,  OP_LD,  OP_ST,
    OP_BEQ, OP_BNE,  OP_JMP, OP_HALT
  } op_t;

  logic [31:0] rom [256];

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  pc;
  logic [7:0]  pc_nxt;
  logic [31:0] ir;
  logic [31:0] rf [16];

  op_t         op;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  ea;
  logic        led_sel;
  logic        uart_sel;
  logic        in_exec;

  logic [31:0] alu_y;
  logic        alu_we;
  logic        rf_we;
  logic [31:0] rf_wd;

  logic [3:0]  addr_q;
  logic [31:0] data_q;
  logic        ld_uart;
  logic [31:0] ld_val;

  assign op   = op_t'(ir[31:28]);
  assign rd   = ir[27:24];
  assign rs1  = ir[23:20];
  assign rs2  = ir[19:16];
  assign imm  = ir[15:0];
  assign sext = {{16{imm[15]}}, imm};

  // r0 is never written, so it keeps its reset value of zero
  assign a = rf[rs1];
  assign b = rf[rs2];

  // only the low byte of the effective address matters for decode
  assign ea       = a[7:0] + imm[7:0];
  assign led_sel  = (ea[7:4] == 4'h0);
  assign uart_sel = (ea[7:4] == 4'h1);
  assign in_exec  = (state == S_EXEC);

  assign io_uart_wr = in_exec && (op == OP_ST) && uart_sel;
  assign io_uart_rd = in_exec && (op == OP_LD) && uart_sel;

  assign io_uart_address =
    (io_uart_wr || io_uart_rd) ? ea[3:0] : addr_q;
  assign io_uart_wr_data = io_uart_wr ? b : data_q;

  always_comb begin
    alu_y  = '0;
    alu_we = 1'b1;
    case (op)
      OP_ADDI: alu_y = a + sext;
      OP_ADD:  alu_y = a + b;
      OP_SUB:  alu_y = a - b;
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_SHL:  alu_y = a << b[4:0];
      OP_SHR:  alu_y = a >> b[4:0];
      OP_LUI:  alu_y = {imm, 16'h0000};
      default: alu_we = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt = pc + 8'd1;
    case (op)
      OP_BEQ:  if (a == b) pc_nxt = pc + 8'd1 + imm[7:0];
      OP_BNE:  if (a != b) pc_nxt = pc + 8'd1 + imm[7:0];
      OP_JMP:  pc_nxt = imm[7:0];
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_y;
    if (in_exec) begin
      rf_we = alu_we;
    end else if (state == S_WB) begin
      rf_we = 1'b1;
      rf_wd = ld_uart ? io_uart_rd_data : ld_val;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT)    state_nxt = S_HALT;
        else if (op == OP_LD) state_nxt = S_WB;
        else                  state_nxt = S_FETCH;
      end
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      io_led   <= '0;
      io_dummy <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ld_uart  <= 1'b0;
      ld_val   <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (state == S_FETCH) ir <= rom[pc];
      if (in_exec) begin
        pc <= pc_nxt;
        if (op == OP_ST && led_sel) io_led <= b[7:0];
        if (io_uart_wr) data_q <= b;
        if (io_uart_wr || io_uart_rd) addr_q <= ea[3:0];
        if (op == OP_LD) begin
          ld_uart <= uart_sel;
          ld_val  <= led_sel ? {24'h0, io_led} : 32'h0;
        end
      end
      if (rf_we) begin
        io_dummy <= rf_wd;
        if (rd != 4'd0) rf[rd] <= rf_wd;
      end
    end
  end

endmodule

// File: tb/tb_patmos.sv
// Bench for patmos: directed and random programs against an
// instruction-level model, checked cycle by cycle at each phase.
module tb_patmos;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] io_dummy;
  logic [7:0]  io_led;
  logic [3:0]  io_uart_address;
  logic [31:0] io_uart_wr_data;
  logic        io_uart_rd;
  logic        io_uart_wr;
  logic [31:0] io_uart_rd_data = '0;

  int n_run = 0;
  int n_fail = 0;

  patmos #(.ROM_FILE("")) dut (
    .clk             (clk),
    .reset           (reset),
    .io_dummy        (io_dummy),
    .io_led          (io_led),
    .io_uart_address (io_uart_address),
    .io_uart_wr_data (io_uart_wr_data),
    .io_uart_rd      (io_uart_rd),
    .io_uart_wr      (io_uart_wr),
    .io_uart_rd_data (io_uart_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] img [256];

  logic [31:0] m_r [16];
  logic [7:0]  m_pc;
  logic [7:0]  m_led;
  logic [31:0] m_dummy;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  bit          m_halt;

  function automatic logic [31:0] enc(input int op, input int rd,
                                      input int rs1, input int rs2,
                                      input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) dut.rom[i] = img[i];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_pc = 0; m_led = 0; m_dummy = 0;
    m_addr = 0; m_data = 0; m_halt = 0;
  endtask

  // Architectural effect of one instruction, plus what the UART port
  // must show during its execute cycle.
  task automatic model_step(input logic [31:0] ins,
                            input logic [31:0] rdata,
                            output logic ewr, output logic erd,
                            output logic [3:0] eaddr,
                            output logic [31:0] edata,
                            output logic is_ld);
    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] x, y, sx, v, full_ea;
    logic [7:0]  npc;
    bit          wr;
    op = ins[31:28]; rd = ins[27:24];
    rs1 = ins[23:20]; rs2 = ins[19:16];
    x = m_r[rs1]; y = m_r[rs2];
    sx = {{16{ins[15]}}, ins[15:0]};
    full_ea = x + sx;
    ewr = 0; erd = 0; is_ld = 0; wr = 0; v = 0;
    eaddr = m_addr; edata = m_data;
    npc = m_pc + 8'd1;
    case (op)
      4'h1: begin v = x + sx; wr = 1; end
      4'h2: begin v = x + y; wr = 1; end
      4'h3: begin v = x - y; wr = 1; end
      4'h4: begin v = x & y; wr = 1; end
      4'h5: begin v = x | y; wr = 1; end
      4'h6: begin v = x ^ y; wr = 1; end
      4'h7: begin v = x << y[4:0]; wr = 1; end
      4'h8: begin v = x >> y[4:0]; wr = 1; end
      4'h9: begin v = {ins[15:0], 16'h0}; wr = 1; end
      4'hA: begin
        is_ld = 1; wr = 1;
        if (full_ea[7:4] == 4'h0) v = {24'h0, m_led};
        else if (full_ea[7:4] == 4'h1) begin
          v = rdata; erd = 1; eaddr = full_ea[3:0];
        end
      end
      4'hB: begin
        if (full_ea[7:4] == 4'h0) m_led = y[7:0];
        else if (full_ea[7:4] == 4'h1) begin
          ewr = 1; eaddr = full_ea[3:0]; edata = y;
        end
      end
      4'hC: if (x == y) npc = m_pc + 8'd1 + ins[7:0];
      4'hD: if (x != y) npc = m_pc + 8'd1 + ins[7:0];
      4'hE: npc = ins[7:0];
      4'hF: begin m_halt = 1; npc = m_pc; end
      default: ;
    endcase
    if (wr) begin
      m_dummy = v;
      if (rd != 0) m_r[rd] = v;
    end
    m_addr = eaddr; m_data = edata; m_pc = npc;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dummy"}, io_dummy, 32'h0);
    chk({tag, "_led"}, {24'h0, io_led}, 32'h0);
    chk({tag, "_addr"}, {28'h0, io_uart_address}, 32'h0);
    chk({tag, "_wdata"}, io_uart_wr_data, 32'h0);
    chk({tag, "_strb"}, {30'h0, io_uart_rd, io_uart_wr}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    load_rom();
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("rst");
    model_reset();
    reset = 1'b1;
  endtask

  task automatic run_prog(input int max_steps, input int rdfix,
                          input bit abort_ld);
    logic [31:0] ins, rdata, edata;
    logic        ewr, erd, ld;
    logic [3:0]  eaddr;
    do_reset();
    for (int s = 0; s < max_steps && !m_halt; s++) begin
      ins = img[m_pc];
      rdata = (rdfix < 0) ? $urandom : rdfix;
      io_uart_rd_data = rdata;
      chk("fetch_strb", {30'h0, io_uart_rd, io_uart_wr}, 32'h0);
      model_step(ins, rdata, ewr, erd, eaddr, edata, ld);
      @(negedge clk);
      chk("exec_wr", {31'h0, io_uart_wr}, {31'h0, ewr});
      chk("exec_rd", {31'h0, io_uart_rd}, {31'h0, erd});
      chk("uart_addr", {28'h0, io_uart_address}, {28'h0, eaddr});
      chk("uart_wdata", io_uart_wr_data, edata);
      if (ld) begin
        @(negedge clk);
        chk("wb_strb", {30'h0, io_uart_rd, io_uart_wr}, 32'h0);
        if (abort_ld) begin
          reset = 1'b0;
          #1;
          chk_zero_outputs("abort");
          return;
        end
      end
      @(negedge clk);
      chk("dummy", io_dummy, m_dummy);
      chk("led", {24'h0, io_led}, {24'h0, m_led});
    end
    if (m_halt) begin
      repeat (3) begin
        @(negedge clk);
        chk("halt_strb", {30'h0, io_uart_rd, io_uart_wr}, 32'h0);
        chk("halt_dummy", io_dummy, m_dummy);
        chk("halt_led", {24'h0, io_led}, {24'h0, m_led});
      end
    end
  endtask

  initial begin
    // ADDI chain with negative immediate
    clear_img();
    img[0] = enc(1, 1, 0, 0, 5);
    img[1] = enc(1, 2, 1, 0, -7);
    img[2] = enc(15, 0, 0, 0, 0);
    run_prog(20, -1, 0);
    chk("p1_final", io_dummy, 32'hFFFF_FFFE);

    // LED store
    clear_img();
    img[0] = enc(1, 1, 0, 0, 'hA5);
    img[1] = enc(11, 0, 0, 1, 'h00);
    img[2] = enc(15, 0, 0, 0, 0);
    run_prog(20, -1, 0);
    chk("p2_led", {24'h0, io_led}, 32'hA5);

    // UART store then load
    clear_img();
    img[0] = enc(1, 1, 0, 0, 'h41);
    img[1] = enc(11, 0, 0, 1, 'h13);
    img[2] = enc(10, 2, 0, 0, 'h12);
    img[3] = enc(15, 0, 0, 0, 0);
    run_prog(20, 7, 0);
    chk("p3_dummy", io_dummy, 32'h7);

    // reset during LD write-back, then clean restart
    run_prog(20, 9, 1);
    run_prog(20, 7, 0);

    // counted loop, forward branch, JMP to 0xFF and wrap
    clear_img();
    img[0]   = enc(1, 4, 4, 0, 1);
    img[1]   = enc(1, 1, 0, 0, 0);
    img[2]   = enc(1, 2, 0, 0, 3);
    img[3]   = enc(1, 1, 1, 0, 1);
    img[4]   = enc(13, 0, 1, 2, -2);
    img[5]   = enc(1, 5, 0, 0, 1);
    img[6]   = enc(12, 0, 4, 5, 1);
    img[7]   = enc(15, 0, 0, 0, 0);
    img[8]   = enc(14, 0, 0, 0, 'hFF);
    img[255] = enc(1, 6, 6, 0, 7);
    run_prog(100, -1, 0);

    // shifts by 33, LUI, r0 writes
    clear_img();
    img[0] = enc(1, 1, 0, 0, 33);
    img[1] = enc(1, 2, 0, 0, 'h55);
    img[2] = enc(7, 3, 2, 1, 0);
    img[3] = enc(8, 4, 2, 1, 0);
    img[4] = enc(9, 5, 0, 0, 'h1234);
    img[5] = enc(1, 0, 0, 0, 5);
    img[6] = enc(2, 6, 0, 0, 0);
    img[7] = enc(2, 7, 3, 4, 0);
    img[8] = enc(15, 0, 0, 0, 0);
    run_prog(30, -1, 0);
    chk("p5_r0", io_dummy, 32'hD4);

    // random programs
    for (int p = 0; p < 6; p++) begin
      clear_img();
      for (int i = 0; i < 8; i++)
        img[i] = enc(1, i + 1, 0, 0, $urandom);
      for (int i = 8; i < 60; i++) begin
        int op, rs1, imm;
        op  = $urandom_range(0, 14);
        rs1 = $urandom_range(0, 15);
        imm = $urandom;
        if ((op == 10 || op == 11) && $urandom_range(0, 1) == 1) begin
          rs1 = 0;
          imm = $urandom_range(0, 31);
        end
        img[i] = enc(op, $urandom_range(0, 15), rs1,
                     $urandom_range(0, 15), imm);
      end
      img[60] = enc(15, 0, 0, 0, 0);
      run_prog(300, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
